// File: rtl/free_list_pkg.sv
// Processor-wide constants shared by the map table, ROB and free list.
package free_list_pkg;

  localparam int PR_NUM   = 64;
  localparam int AR_NUM   = 32;
  localparam int TAG_W    = 7;
  localparam int FL_DEPTH = PR_NUM - AR_NUM;
  localparam int PTR_W    = $clog2(FL_DEPTH);

  typedef logic [TAG_W-1:0] tag_t;

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch/retire/offer bundle between the rename stage, ROB and the free list.
interface free_list_if;
  import free_list_pkg::*;

  logic [1:0] id_dispatch_num;
  logic       recover;
  logic [1:0] rob_retire_num;
  tag_t       rob_retire_told0;
  tag_t       rob_retire_told1;
  tag_t       fl_pr0;
  tag_t       fl_pr1;
  logic [1:0] fl_avail_num;
  logic [6:0] fl_count;
  logic       fl_err;

  modport master (
    output id_dispatch_num, recover, rob_retire_num, rob_retire_told0, rob_retire_told1,
    input  fl_pr0, fl_pr1, fl_avail_num, fl_count, fl_err
  );

  modport slave (
    input  id_dispatch_num, recover, rob_retire_num, rob_retire_told0, rob_retire_told1,
    output fl_pr0, fl_pr1, fl_avail_num, fl_count, fl_err
  );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags: allocates up to two per cycle,
// frees up to two per cycle, and rewinds head to retire_head on recovery.
module free_list #(
  parameter int PR_NUM   = free_list_pkg::PR_NUM,
  parameter int FL_DEPTH = PR_NUM - free_list_pkg::AR_NUM
) (
  input logic       clk,
  input logic       rst_n,
  free_list_if.slave fl
);
  import free_list_pkg::*;

  localparam int PW = $clog2(FL_DEPTH);

  typedef struct packed {
    logic          wrap;
    logic [PW-1:0] idx;
  } ptr_t;

  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    ptr_t        r;
    logic [PW:0] s;
    s = {1'b0, p.idx} + (PW+1)'(n);
    if (s >= (PW+1)'(FL_DEPTH)) begin
      r.idx  = PW'(s - (PW+1)'(FL_DEPTH));
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = s[PW-1:0];
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  // Entries between head and tail; differing wrap bits mean tail has lapped head.
  function automatic logic [PW:0] ptr_diff(input ptr_t t, input ptr_t h);
    if (t.wrap == h.wrap) begin
      return {1'b0, t.idx} - {1'b0, h.idx};
    end else begin
      return (PW+1)'(FL_DEPTH) - {1'b0, h.idx} + {1'b0, t.idx};
    end
  endfunction

  tag_t        buf_q [FL_DEPTH];
  tag_t        buf_d [FL_DEPTH];
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  ptr_t        rhead_q, rhead_d;
  logic        err_q, err_d;

  logic [PW:0]   count_s;
  logic [1:0]    avail_s;
  logic [1:0]    rnum_s;
  logic [1:0]    grant_s;
  logic [PW+1:0] space_s;
  logic [1:0]    accept_s;
  ptr_t          head_p1_s;
  ptr_t          tail_p1_s;

  assign count_s   = ptr_diff(tail_q, head_q);
  assign avail_s   = (count_s >= (PW+1)'(2)) ? 2'd2 : count_s[1:0];
  assign head_p1_s = ptr_add(head_q, 2'd1);
  assign tail_p1_s = ptr_add(tail_q, 2'd1);

  assign fl.fl_pr0       = buf_q[head_q.idx];
  assign fl.fl_pr1       = buf_q[head_p1_s.idx];
  assign fl.fl_avail_num = avail_s;
  assign fl.fl_count     = 7'(count_s);
  assign fl.fl_err       = err_q;

  // Grant/accept counts, pointer updates and the sticky error.
  always_comb begin
    rnum_s  = min2(fl.rob_retire_num, 2'd2);
    grant_s = 2'd0;
    if (!fl.recover) begin
      grant_s = min2(fl.id_dispatch_num, avail_s);
    end else begin
      grant_s = 2'd0;
    end
    // Slots leaving at head this cycle may be refilled at tail in the same cycle.
    space_s = (PW+2)'(FL_DEPTH) - (PW+2)'(count_s) + (PW+2)'(grant_s);
    if (space_s >= (PW+2)'(rnum_s)) begin
      accept_s = rnum_s;
    end else begin
      accept_s = space_s[1:0];
    end
    tail_d  = ptr_add(tail_q, accept_s);
    rhead_d = ptr_add(rhead_q, rnum_s);
    if (fl.recover) begin
      head_d = rhead_d;
    end else begin
      head_d = ptr_add(head_q, grant_s);
    end
    err_d = err_q
          | (~fl.recover & (fl.id_dispatch_num > avail_s))
          | (space_s < (PW+2)'(rnum_s))
          | (fl.rob_retire_num == 2'd3);
  end

  // Told-tag writes at tail and tail+1.
  always_comb begin
    for (int i = 0; i < FL_DEPTH; i++) begin
      if ((accept_s != 2'd0) && (tail_q.idx == PW'(i))) begin
        buf_d[i] = fl.rob_retire_told0;
      end else if ((accept_s == 2'd2) && (tail_p1_s.idx == PW'(i))) begin
        buf_d[i] = fl.rob_retire_told1;
      end else begin
        buf_d[i] = buf_q[i];
      end
    end
  end

  // State registers; reset leaves the list full with tags above the architectural set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        buf_q[i] <= TAG_W'(PR_NUM - FL_DEPTH + i);
      end
      head_q  <= '{wrap: 1'b0, idx: '0};
      rhead_q <= '{wrap: 1'b0, idx: '0};
      tail_q  <= '{wrap: 1'b1, idx: '0};
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector tables plus randomized
// traffic against an unbounded-counter model of the circular list.
module tb_free_list;
  localparam int D = 32;

  typedef struct {
    int d, rec, rn, t0, t1;
    int pr0, pr1, av, cnt, err;
  } vec_t;

  logic clk;
  logic rst_n;
  free_list_if fl_if();

  free_list dut (.clk(clk), .rst_n(rst_n), .fl(fl_if));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  int m_buf [D];
  int m_head, m_tail, m_rh;
  int m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_buf[i] = 32 + i;
    m_head = 0; m_rh = 0; m_tail = D; m_err = 0;
  endtask

  task automatic drive(input int d, input int rec, input int rn, input int t0, input int t1);
    fl_if.id_dispatch_num  = 2'(d);
    fl_if.recover          = 1'(rec);
    fl_if.rob_retire_num   = 2'(rn);
    fl_if.rob_retire_told0 = 7'(t0);
    fl_if.rob_retire_told1 = 7'(t1);
  endtask

  // One clock: drive at negedge, compare against the model (and optional constants), advance model.
  task automatic step(input vec_t v, input bit use_exp);
    int cnt, av, g, r, space, acc;
    @(negedge clk);
    drive(v.d, v.rec, v.rn, v.t0, v.t1);
    #1;
    cnt = m_tail - m_head;
    av  = (cnt < 2) ? cnt : 2;
    chk("model_pr0",   int'(fl_if.fl_pr0),       m_buf[m_head % D]);
    chk("model_pr1",   int'(fl_if.fl_pr1),       m_buf[(m_head + 1) % D]);
    chk("model_avail", int'(fl_if.fl_avail_num), av);
    chk("model_count", int'(fl_if.fl_count),     cnt);
    chk("model_err",   int'(fl_if.fl_err),       m_err);
    if (use_exp) begin
      chk("vec_pr0",   int'(fl_if.fl_pr0),       v.pr0);
      chk("vec_pr1",   int'(fl_if.fl_pr1),       v.pr1);
      chk("vec_avail", int'(fl_if.fl_avail_num), v.av);
      chk("vec_count", int'(fl_if.fl_count),     v.cnt);
      chk("vec_err",   int'(fl_if.fl_err),       v.err);
    end
    r = v.rn;
    g = v.rec ? 0 : ((v.d < av) ? v.d : av);
    if (!v.rec && v.d > av) m_err = 1;
    space = D - cnt + g;
    acc = (r < space) ? r : space;
    if (r > space) m_err = 1;
    if (acc >= 1) m_buf[m_tail % D] = v.t0;
    if (acc == 2) m_buf[(m_tail + 1) % D] = v.t1;
    m_tail += acc;
    m_rh   += r;
    m_head  = v.rec ? m_rh : (m_head + g);
    @(posedge clk);
  endtask

  // Reset asserted asynchronously while traffic is being driven.
  task automatic do_reset();
    @(negedge clk);
    drive(2, 1, 2, 11, 12);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pr0",   int'(fl_if.fl_pr0),       32);
    chk("rst_pr1",   int'(fl_if.fl_pr1),       33);
    chk("rst_avail", int'(fl_if.fl_avail_num), 2);
    chk("rst_count", int'(fl_if.fl_count),     32);
    chk("rst_err",   int'(fl_if.fl_err),       0);
    @(posedge clk);
    #1;
    chk("rst_hold_count", int'(fl_if.fl_count), 32);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
  endtask

  function automatic vec_t mk(input int d, input int rec, input int rn, input int t0, input int t1,
                              input int pr0, input int pr1, input int av, input int cnt, input int err);
    vec_t v;
    v.d = d; v.rec = rec; v.rn = rn; v.t0 = t0; v.t1 = t1;
    v.pr0 = pr0; v.pr1 = pr1; v.av = av; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  initial begin
    vec_t tbl [7];
    vec_t nv;
    clk = 1'b0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Offer after reset, recovery with concurrent retire, then overflowing free.
    tbl[0] = mk(2, 0, 0, 0, 0, 32, 33, 2, 32, 0);
    tbl[1] = mk(2, 0, 0, 0, 0, 34, 35, 2, 30, 0);
    tbl[2] = mk(2, 0, 0, 0, 0, 36, 37, 2, 28, 0);
    tbl[3] = mk(2, 1, 2, 3, 4, 38, 39, 2, 26, 0);
    tbl[4] = mk(0, 0, 0, 0, 0, 34, 35, 2, 32, 0);
    tbl[5] = mk(0, 0, 1, 9, 0, 34, 35, 2, 32, 0);
    tbl[6] = mk(0, 0, 0, 0, 0, 34, 35, 2, 32, 1);
    for (int i = 0; i < 7; i++) step(tbl[i], 1'b1);

    // Drain to one entry, over-request, then refill from empty.
    do_reset();
    nv = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(nv, 1'b0);
    nv.d = 1;
    step(nv, 1'b0);
    step(mk(2, 0, 0, 0, 0, 63, 32, 1, 1, 0), 1'b1);
    step(mk(0, 0, 2, 5, 7, 32, 33, 0, 0, 1), 1'b1);
    step(mk(0, 0, 0, 0, 0, 5, 7, 2, 2, 1), 1'b1);

    // Steady allocate-2/free-2 traffic wraps every pointer.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      nv = mk(2, 0, 2, 32 + (i % 32), 32 + ((i + 7) % 32), 0, 0, 0, 0, 0);
      step(nv, 1'b0);
      #1;
      chk("steady_count", int'(fl_if.fl_count), 32);
      chk("steady_err",   int'(fl_if.fl_err),   0);
    end

    // Randomized traffic with retires bounded by outstanding allocations.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int outs, rmax;
      outs = m_head - m_rh;
      rmax = (outs < 2) ? outs : 2;
      nv = mk(int'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0) ? 1 : 0,
              int'($urandom_range(0, rmax)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), 0, 0, 0, 0, 0);
      step(nv, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter PR_NUM, default 64, total physical registers; tags 0..31 are the reset architectural mapping.
REQ-002 Parameter FL_DEPTH, default PR_NUM-32, free-list capacity in entries.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_dispatch_num  input  2  number of tags requested this cycle (0..2).
REQ-006 recover  input  1  branch-mispredict/exception recovery pulse.
REQ-007 rob_retire_num  input  2  instructions retiring this cycle (0..2).
REQ-008 rob_retire_told0, rob_retire_told1  input  7 each  previous-mapping tags freed by retiring instructions 0 and 1.
REQ-009 fl_pr0, fl_pr1  output  7 each  next two free tags offered to dispatch.
REQ-010 fl_avail_num  output  2  grantable count: min(count, 2).
REQ-011 fl_count  output  7  current number of free entries.
REQ-012 fl_err  output  1  sticky protocol-error flag.

Function
REQ-013 Storage SHALL be a circular buffer of FL_DEPTH 7-bit tags with head, tail and retire_head pointers, each log2(FL_DEPTH) bits plus a wrap bit.
REQ-014 fl_count SHALL equal tail minus head (wrap-bit arithmetic): empty when pointers are equal; full when indices match and wrap bits differ.
REQ-015 fl_pr0 SHALL be buffer[head] and fl_pr1 buffer[head+1 mod FL_DEPTH], combinational from registered state (zero-cycle offer).
REQ-016 Allocation: head SHALL advance by g = min(id_dispatch_num, fl_avail_num) when recover is low.
REQ-017 If id_dispatch_num > fl_avail_num, only g tags SHALL be granted and fl_err SHALL be set.
REQ-018 Free: told0 SHALL be written at tail when rob_retire_num >= 1, told1 at tail+1 when rob_retire_num == 2; tail SHALL advance by rob_retire_num.
REQ-019 A free pushing fl_count above FL_DEPTH SHALL be dropped for the excess entries and SHALL set fl_err.
REQ-020 retire_head SHALL advance by rob_retire_num every cycle, including recover cycles (each retiring instruction owns exactly one allocation).
REQ-021 Tags freed in cycle N SHALL NOT be offered before cycle N+1; no same-cycle bypass.
REQ-022 Simultaneous allocation and free SHALL both take effect; fl_count(N+1) = fl_count(N) - g + rob_retire_num.
REQ-023 On recover, head SHALL load the post-update retire_head value, id_dispatch_num SHALL be ignored, and tail SHALL still process that cycle's retires.
REQ-024 All pointer arithmetic SHALL wrap modulo FL_DEPTH, toggling the wrap bit.
REQ-025 fl_err SHALL clear only on reset.

Reset
REQ-026 While reset is low: buffer[i] = 32+i; head = retire_head = 0; tail index 0 with wrap bit 1 (full); fl_err = 0.
REQ-027 Outputs after reset: fl_pr0 = 32, fl_pr1 = 33, fl_avail_num = 2, fl_count = FL_DEPTH.
REQ-028 Reset asserted mid-operation SHALL override recover, dispatch and retire immediately and asynchronously.

Structure
REQ-029 PR_NUM, AR_NUM (32), FL_DEPTH, PTR_W and the 7-bit tag width SHALL live in the shared processor constants package used by the map table and ROB.
REQ-030 The block SHALL be a single module with no sub-modules; pointer increment logic is inline.

Verification
REQ-031 Reset, then dispatch 2 -> fl_pr0=32, fl_pr1=33 that cycle; next cycle fl_pr0=34, fl_pr1=35, fl_count=30.
REQ-032 Drain to fl_count=1, request 2 -> one grant (tag 63), fl_err=1, fl_count=0, fl_avail_num=0.
REQ-033 fl_count=0, retire 2 with told 5, 7 -> fl_avail_num=0 in that cycle; next cycle fl_pr0=5, fl_pr1=7, fl_count=2.
REQ-034 Dispatch 6 (tags 32..37), retire 2 (told 3, 4) with recover in the same cycle -> head=retire_head=2, fl_pr0=34, fl_count=32.
REQ-035 Full list, retire 1 with told 9 -> entry dropped, fl_err=1, fl_count stays 32.
REQ-036 Dispatch 2 and retire 2 every cycle for 40 cycles -> fl_count stays 32, pointers wrap, fl_err=0.
